// File: rtl/imm_encode_pkg.sv
// Shared types and helpers for the RV32I immediate encoder: format selects, FSM states, range limits.
// Pure declarations and combinational functions; no state, no flow control.
package imm_encode_pkg;

  localparam logic [2:0] IMM_SEL_I = 3'b000;
  localparam logic [2:0] IMM_SEL_S = 3'b001;
  localparam logic [2:0] IMM_SEL_U = 3'b010;
  localparam logic [2:0] IMM_SEL_B = 3'b011;
  localparam logic [2:0] IMM_SEL_J = 3'b100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int I_IMM_MIN = -2048;
  localparam int I_IMM_MAX = 2047;
  localparam int B_IMM_MIN = -4096;
  localparam int B_IMM_MAX = 4094;
  localparam int J_IMM_MIN = -1048576;
  localparam int J_IMM_MAX = 1048574;

  function automatic logic [31:0] encode_instr(
    input logic [2:0]  sel,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [2:0]  f3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (sel)
      IMM_SEL_I: w = {imm[11:0], rs1, f3, rd, op};
      IMM_SEL_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      IMM_SEL_U: w = {imm[31:12], rd, op};
      IMM_SEL_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      IMM_SEL_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:   w = NOP_INSTR;
    endcase
    return w;
  endfunction

  // Flags immediates that the chosen format cannot represent exactly.
  function automatic logic imm_range_err(input logic [2:0] sel, input logic [31:0] imm);
    int  v;
    logic e;
    v = $signed(imm);
    case (sel)
      IMM_SEL_I, IMM_SEL_S: e = (v < I_IMM_MIN) || (v > I_IMM_MAX);
      IMM_SEL_B:            e = (v < B_IMM_MIN) || (v > B_IMM_MAX) || imm[0];
      IMM_SEL_J:            e = (v < J_IMM_MIN) || (v > J_IMM_MAX) || imm[0];
      IMM_SEL_U:            e = (imm[11:0] != 12'h000);
      default:              e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_instr_encoder_if.sv
// Field-bundle input, encoded-word output and load control of the immediate encoder.
// slave = encoder side, master = program source / loader side.
interface imm_instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [CNT_W-1:0]  prog_len;
  logic              busy;
  logic              done;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_imm_sel;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output start, prog_len, in_valid, in_imm_sel, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_imm, out_ready,
    input  busy, done, in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  start, prog_len, in_valid, in_imm_sel, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_imm, out_ready,
    output busy, done, in_ready, out_valid, out_instr, out_addr, out_err
  );

endinterface

// File: rtl/imm_fifo2.sv
// Two-entry valid/ready buffer; 1-cycle push-to-head latency.
// push_rdy low only when full and the head is not being popped; push+pop when full keeps count.
module imm_fifo2 #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign pop_vld  = (cnt != 2'd0);
  assign push_rdy = (cnt != 2'd2) || pop_rdy;
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= RST_VAL;
      mem[1] <= RST_VAL;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // When full, wr_ptr equals rd_ptr; overwriting is safe because that head pops this cycle.
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/imm_instr_encoder.sv
// Packs register fields + immediate into RV32I I/S/U/B/J words with incrementing byte addresses;
// 1-cycle accept-to-output, in_ready drops while the 2-entry buffer is full; IMM_RANGE_CHECK_EN adds out_err.
module imm_instr_encoder
  import imm_encode_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input logic                clk,
  input logic                reset,
  imm_instr_encoder_if.slave bus
);
  localparam int PW = 1 + ADDR_W + 32;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  emit_cnt;
  logic [ADDR_W-1:0] addr_q;

  logic              in_rdy;
  logic              push;
  logic              pop;
  logic              fifo_push_rdy;
  logic              fifo_vld;
  logic [PW-1:0]     fifo_dat;
  logic [31:0]       enc_instr;
  logic              enc_err;

  assign enc_instr = encode_instr(bus.in_imm_sel, bus.in_opcode, bus.in_rd, bus.in_funct3,
                                  bus.in_rs1, bus.in_rs2, bus.in_imm);

`ifdef IMM_RANGE_CHECK_EN
  assign enc_err = imm_range_err(bus.in_imm_sel, bus.in_imm);
`else
  assign enc_err = 1'b0;
`endif

  assign pop  = fifo_vld && bus.out_ready;
  assign push = bus.in_valid && in_rdy;

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.prog_len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_rdy = fifo_push_rdy && (acc_cnt < len_q);
        // Leave LOAD once the final word has been taken by the consumer.
        if (pop && ((emit_cnt + CNT_W'(1)) == len_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      acc_cnt  <= '0;
      emit_cnt <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && bus.start) begin
        len_q    <= bus.prog_len;
        acc_cnt  <= '0;
        emit_cnt <= '0;
        addr_q   <= BASE_ADDR;
      end else begin
        if (push) begin
          acc_cnt <= acc_cnt + CNT_W'(1);
          addr_q  <= addr_q + ADDR_W'(4);
        end
        if (pop) begin
          emit_cnt <= emit_cnt + CNT_W'(1);
        end
      end
    end
  end

  imm_fifo2 #(
    .W       (PW),
    .RST_VAL ({1'b0, BASE_ADDR, 32'h0000_0000})
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push),
    .push_rdy (fifo_push_rdy),
    .push_dat ({enc_err, addr_q, enc_instr}),
    .pop_vld  (fifo_vld),
    .pop_rdy  (bus.out_ready),
    .pop_dat  (fifo_dat)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = fifo_vld;
  assign {bus.out_err, bus.out_addr, bus.out_instr} = fifo_dat;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: directed format vectors, range edges, backpressure, resets, random loads.
module tb_imm_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_instr_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  imm_instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bundle_t     stim_q[$];
  logic [31:0] obs_instr[$];
  logic [31:0] obs_addr[$];
  logic        obs_err[$];
  int done_cnt, done_cyc, last_hs_cyc, max_fill, acc_at_stall, stab_viol, over_acc;
  bit timed_out;

  int edges [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                     1048574, 1048576, -1048576, -1048578, 32'h1234_5000};

  // Reference: field placement from the RV32I format tables, built with shifts and masks.
  function automatic logic [31:0] ref_word(input bundle_t b);
    logic [31:0] imm, rd, f3, rs1, rs2, op;
    imm = b.imm;
    rd  = 32'(b.rd) << 7;
    f3  = 32'(b.f3) << 12;
    rs1 = 32'(b.rs1) << 15;
    rs2 = 32'(b.rs2) << 20;
    op  = 32'(b.op);
    case (b.sel)
      3'd0: return ((imm & 32'hFFF) << 20) | rs1 | f3 | rd | op;
      3'd1: return (((imm >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((imm & 32'h1F) << 7) | op;
      3'd2: return (imm & 32'hFFFF_F000) | rd | op;
      3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2 | rs1 | f3
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
      3'd4: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rd | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bit range_bad(input bundle_t b);
    longint v;
    v = longint'($signed(b.imm));
    case (b.sel)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (b.imm % 32'd4096) != 0;
      3'd3:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
      3'd4:       return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic bundle_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    bundle_t b;
    b.sel = sel; b.op = op; b.rd = rd; b.f3 = f3; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return edges[$urandom_range(0, 13)];
      default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
  endfunction

  function automatic bundle_t rand_bundle(input bit legal_only);
    bundle_t b;
    b.sel = legal_only ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
    b.op  = 7'($urandom);
    b.rd  = 5'($urandom);
    b.f3  = 3'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    b.imm = pick_imm();
    return b;
  endfunction

  task automatic drive_bundle(input bundle_t b);
    bus.in_imm_sel = b.sel;
    bus.in_opcode  = b.op;
    bus.in_rd      = b.rd;
    bus.in_funct3  = b.f3;
    bus.in_rs1     = b.rs1;
    bus.in_rs2     = b.rs2;
    bus.in_imm     = b.imm;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.prog_len  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_bundle('0);
  endtask

  // Runs one program load and records what the consumer side saw; inputs change at negedge.
  task automatic run_load(input int len, input int vld_pct, input int rdy_pct, input int stall);
    int acc, cyc;
    bit hold;
    logic [31:0] h_instr, h_addr;
    logic h_err;
    acc = 0; cyc = 0; hold = 1'b0; h_instr = '0; h_addr = '0; h_err = 1'b0;
    obs_instr.delete(); obs_addr.delete(); obs_err.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; max_fill = 0; acc_at_stall = -1;
    stab_viol = 0; over_acc = 0; timed_out = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.prog_len = 16'(len);
    @(negedge clk); bus.start = 1'b0;
    forever begin
      if (acc < stim_q.size()) begin
        drive_bundle(stim_q[acc]);
        bus.in_valid = ($urandom_range(0, 99) < vld_pct);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (cyc >= stall) && ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (hold && (bus.out_valid !== 1'b1 || bus.out_instr !== h_instr ||
                   bus.out_addr !== h_addr || bus.out_err !== h_err)) stab_viol++;
      hold = (bus.out_valid === 1'b1) && !bus.out_ready;
      h_instr = bus.out_instr; h_addr = bus.out_addr; h_err = bus.out_err;
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.in_ready === 1'b1 && acc >= len) over_acc++;
      if (bus.in_valid && bus.in_ready === 1'b1) acc++;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        obs_instr.push_back(bus.out_instr);
        obs_addr.push_back(bus.out_addr);
        obs_err.push_back(bus.out_err);
        last_hs_cyc = cyc;
      end
      if (acc - obs_instr.size() > max_fill) max_fill = acc - obs_instr.size();
      if (cyc == stall - 1) acc_at_stall = acc;
      if (bus.busy !== 1'b1) break;
      if (cyc >= 3000) begin timed_out = 1'b1; break; end
      @(negedge clk); cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.prog_len = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
    n_cmp++; if (bus.out_addr !== BASE) begin n_bad++; $display("FAIL reset_out_addr got=%h exp=%h", bus.out_addr, BASE); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_formats();
    bundle_t     tbl [4];
    logic [31:0] expw [4];
    tbl[0] = mk(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'($urandom), 32'd5);            expw[0] = 32'h0050_0093;
    tbl[1] = mk(3'd1, 7'h23, 5'($urandom), 3'd2, 5'd3, 5'd2, 32'd8);            expw[1] = 32'h0021_A423;
    tbl[2] = mk(3'd2, 7'h37, 5'd5, 3'($urandom), 5'($urandom), 5'($urandom), 32'h1234_5000); expw[2] = 32'h1234_52B7;
    tbl[3] = mk(3'd3, 7'h63, 5'($urandom), 3'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);     expw[3] = 32'hFE20_8EE3;
    for (int i = 0; i < 4; i++) begin
      stim_q.delete();
      stim_q.push_back(tbl[i]);
      run_load(1, 100, 100, 0);
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL fmt%0d_timeout got=%b exp=0", i, timed_out); end
      n_cmp++;
      if (obs_instr.size() != 1) begin
        n_bad++; $display("FAIL fmt%0d_count got=%0d exp=1", i, obs_instr.size());
      end else begin
        n_cmp++; if (obs_instr[0] !== expw[i]) begin n_bad++; $display("FAIL fmt%0d_instr got=%h exp=%h", i, obs_instr[0], expw[i]); end
        n_cmp++; if (obs_addr[0] !== BASE) begin n_bad++; $display("FAIL fmt%0d_addr got=%h exp=%h", i, obs_addr[0], BASE); end
        n_cmp++; if (obs_err[0] !== 1'b0) begin n_bad++; $display("FAIL fmt%0d_err got=%b exp=0", i, obs_err[0]); end
      end
      n_cmp++; if (last_hs_cyc != 1) begin n_bad++; $display("FAIL fmt%0d_latency got=%0d exp=1", i, last_hs_cyc); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL fmt%0d_done_cnt got=%0d exp=1", i, done_cnt); end
      n_cmp++; if (done_cyc != last_hs_cyc + 1) begin n_bad++; $display("FAIL fmt%0d_done_cyc got=%0d exp=%0d", i, done_cyc, last_hs_cyc + 1); end
    end
  endtask

  task automatic test_range();
    logic [31:0] expw [8];
    logic        expe [8];
    stim_q.delete();
    stim_q.push_back(mk(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048));
    stim_q.push_back(mk(3'd0, 7'h13, 5'd2, 3'd1, 5'd4, 5'd0, 32'hFFFF_F800));
    stim_q.push_back(mk(3'd3, 7'h63, 5'd0, 3'd1, 5'd7, 5'd9, 32'd4094));
    stim_q.push_back(mk(3'd3, 7'h63, 5'd0, 3'd1, 5'd7, 5'd9, 32'd4096));
    stim_q.push_back(mk(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd3));
    stim_q.push_back(mk(3'd2, 7'h17, 5'd3, 3'd0, 5'd0, 5'd0, 32'h1234_5001));
    stim_q.push_back(mk(3'd5, 7'h33, 5'd6, 3'd2, 5'd8, 5'd9, 32'd12));
    stim_q.push_back(mk(3'd4, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFF0_0000));
    expw[0] = 32'h8000_0093;          expe[0] = CHECK_EN;
    expw[1] = ref_word(stim_q[1]);    expe[1] = 1'b0;
    expw[2] = ref_word(stim_q[2]);    expe[2] = 1'b0;
    expw[3] = ref_word(stim_q[3]);    expe[3] = CHECK_EN;
    expw[4] = ref_word(stim_q[4]);    expe[4] = CHECK_EN;
    expw[5] = ref_word(stim_q[5]);    expe[5] = CHECK_EN;
    expw[6] = 32'h0000_0013;          expe[6] = CHECK_EN;
    expw[7] = ref_word(stim_q[7]);    expe[7] = 1'b0;
    run_load(8, 80, 80, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL range_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs_instr.size() != 8) begin n_bad++; $display("FAIL range_count got=%0d exp=8", obs_instr.size()); end
    for (int i = 0; i < obs_instr.size() && i < 8; i++) begin
      n_cmp++; if (obs_instr[i] !== expw[i]) begin n_bad++; $display("FAIL range%0d_instr got=%h exp=%h", i, obs_instr[i], expw[i]); end
      n_cmp++; if (obs_err[i] !== expe[i]) begin n_bad++; $display("FAIL range%0d_err got=%b exp=%b", i, obs_err[i], expe[i]); end
      n_cmp++; if (obs_addr[i] !== BASE + 32'(4 * i)) begin n_bad++; $display("FAIL range%0d_addr got=%h exp=%h", i, obs_addr[i], BASE + 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(rand_bundle(1'b1));
    run_load(3, 100, 100, 4);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (acc_at_stall != 2) begin n_bad++; $display("FAIL bp_accepts_while_stalled got=%0d exp=2", acc_at_stall); end
    n_cmp++; if (max_fill != 2) begin n_bad++; $display("FAIL bp_max_fill got=%0d exp=2", max_fill); end
    n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
    n_cmp++; if (obs_instr.size() != 3) begin n_bad++; $display("FAIL bp_count got=%0d exp=3", obs_instr.size()); end
    for (int i = 0; i < obs_instr.size() && i < 3; i++) begin
      n_cmp++; if (obs_addr[i] !== BASE + 32'(4 * i)) begin n_bad++; $display("FAIL bp%0d_addr got=%h exp=%h", i, obs_addr[i], BASE + 32'(4 * i)); end
      n_cmp++; if (obs_instr[i] !== ref_word(stim_q[i])) begin n_bad++; $display("FAIL bp%0d_instr got=%h exp=%h", i, obs_instr[i], ref_word(stim_q[i])); end
    end
    n_cmp++; if (done_cyc != last_hs_cyc + 1) begin n_bad++; $display("FAIL bp_done_cyc got=%0d exp=%0d", done_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_back_to_back();
    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(rand_bundle(1'b0));
    run_load(10, 100, 100, 0);
    n_cmp++; if (obs_instr.size() != 10) begin n_bad++; $display("FAIL b2b_count got=%0d exp=10", obs_instr.size()); end
    n_cmp++; if (done_cyc != 11) begin n_bad++; $display("FAIL b2b_done_cyc got=%0d exp=11", done_cyc); end
    for (int i = 0; i < obs_instr.size() && i < 10; i++) begin
      n_cmp++; if (obs_instr[i] !== ref_word(stim_q[i])) begin n_bad++; $display("FAIL b2b%0d_instr got=%h exp=%h", i, obs_instr[i], ref_word(stim_q[i])); end
      n_cmp++; if (obs_addr[i] !== BASE + 32'(4 * i)) begin n_bad++; $display("FAIL b2b%0d_addr got=%h exp=%h", i, obs_addr[i], BASE + 32'(4 * i)); end
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(12, 24);
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(rand_bundle(1'b0));
      run_load(len, 70, 60, 0);
      n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout got=%b exp=0", r, timed_out); end
      n_cmp++; if (obs_instr.size() != len) begin n_bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, obs_instr.size(), len); end
      n_cmp++; if (over_acc != 0) begin n_bad++; $display("FAIL rnd%0d_over_accept got=%0d exp=0", r, over_acc); end
      n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL rnd%0d_stable got=%0d exp=0", r, stab_viol); end
      n_cmp++; if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin n_bad++; $display("FAIL rnd%0d_done got=%0d@%0d exp=1@%0d", r, done_cnt, done_cyc, last_hs_cyc + 1); end
      for (int i = 0; i < obs_instr.size() && i < len; i++) begin
        n_cmp++; if (obs_instr[i] !== ref_word(stim_q[i])) begin n_bad++; $display("FAIL rnd%0d_%0d_instr got=%h exp=%h", r, i, obs_instr[i], ref_word(stim_q[i])); end
        n_cmp++; if (obs_addr[i] !== BASE + 32'(4 * i)) begin n_bad++; $display("FAIL rnd%0d_%0d_addr got=%h exp=%h", r, i, obs_addr[i], BASE + 32'(4 * i)); end
        n_cmp++; if (obs_err[i] !== (CHECK_EN && range_bad(stim_q[i]))) begin n_bad++; $display("FAIL rnd%0d_%0d_err got=%b exp=%b", r, i, obs_err[i], CHECK_EN && range_bad(stim_q[i])); end
      end
    end
  endtask

  task automatic test_zero_len();
    stim_q.delete();
    run_load(0, 100, 100, 0);
    n_cmp++; if (obs_instr.size() != 0) begin n_bad++; $display("FAIL zero_count got=%0d exp=0", obs_instr.size()); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 0) begin n_bad++; $display("FAIL zero_done got=%0d@%0d exp=1@0", done_cnt, done_cyc); end
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL zero_timeout got=%b exp=0", timed_out); end
  endtask

  task automatic test_reset_midload();
    bundle_t b;
    @(negedge clk); bus.start = 1'b1; bus.prog_len = 16'd5;
    @(negedge clk); bus.start = 1'b0;
    b = rand_bundle(1'b1);
    drive_bundle(b);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_full got=v%b r%b exp=v1 r0", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.out_addr !== BASE) begin n_bad++; $display("FAIL midrst_out_addr got=%h exp=%h", bus.out_addr, BASE); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done%0d got=%b exp=0", i, bus.done); end
    end
    stim_q.delete();
    stim_q.push_back(rand_bundle(1'b1));
    run_load(1, 100, 100, 0);
    n_cmp++;
    if (obs_addr.size() != 1) begin
      n_bad++; $display("FAIL midrst_restart_count got=%0d exp=1", obs_addr.size());
    end else if (obs_addr[0] !== BASE || obs_instr[0] !== ref_word(stim_q[0])) begin
      n_bad++; $display("FAIL midrst_restart got=%h/%h exp=%h/%h", obs_addr[0], obs_instr[0], BASE, ref_word(stim_q[0]));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_formats();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_zero_len();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
